hall_velocity_estimator: RTL
============================

// Module: hall_velocity_estimator
// PURPOSE
//  Produces the signed actual_velocity word and the update-enable pulse consumed by the BLDC PI
//  velocity controller. Decodes 3-bit hall sensor commutation states and measures clk cycles
//  between valid adjacent transitions. Converts period to velocity via a sequential divider.
//  Forces zero velocity on stall timeout.
// PARAMETERS
//  VEL_NUMERATOR   32'd50_000_000  velocity = VEL_NUMERATOR / period_cycles (clk Hz -> transitions/s)
//  TIMEOUT_CYCLES  24'd5_000_000   cycles without transition before velocity forced to 0; must be > 64
//  PERIOD_WIDTH    24              width of period counter; TIMEOUT_CYCLES must fit
// PORTS
//  clk             in   1    system clock
//  reset_n         in   1    asynchronous, active-low reset
//  hall_raw        in   3    unsynchronised hall sensors {C,B,A}
//  error_clear     in   1    single-cycle pulse, clears hall_error
//  velocity        out  16   signed; positive = forward; held between updates
//  velocity_valid  out  1    one-cycle pulse on every velocity update (drives PI enable)
//  direction       out  1    1 = forward, 0 = reverse; last accepted transition
//  hall_error      out  1    sticky: invalid code (000/111) or non-adjacent jump seen
// BEHAVIOUR
//  Reset: velocity=0, velocity_valid=0, direction=1, hall_error=0, period counter=0, state UNPRIMED,
//   pending flag clear, sync regs=000. Reset mid-divide aborts; no valid pulse follows.
//  Input: 2-FF synchroniser plus 1 history reg. strobe fires when synced code != history.
//   A raw change reaches strobe on the 3rd clk edge.
//  Forward sequence index 0..5 = 001,011,010,110,100,101 (wraps 5->0).
//   Index diff +1 mod 6 = forward. -1 mod 6 = reverse.
//  Code 000/111: hall_error<=1. History not updated, counter not reset, no other effect.
//  Valid code, diff of 2 or 3: hall_error<=1, history updated, counter restarts, state -> UNPRIMED.
//  Period counter: loads 1 on every accepted strobe, else increments; saturates at TIMEOUT_CYCLES.
//   Period is never 0.
//  States:
//   UNPRIMED: adjacent transition -> PRIMED (restart counter, set direction). No velocity computed.
//   PRIMED: adjacent transition -> latch period, set direction, start divide -> DIVIDE.
//    Counter reaching TIMEOUT_CYCLES -> velocity<=0, one valid pulse -> UNPRIMED.
//   DIVIDE: 32-iteration restoring divide of VEL_NUMERATOR by latched period, 1 bit/clk.
//    Strobe at cycle T -> velocity and velocity_valid on cycle T+33.
//    Then -> PRIMED, or restart DIVIDE if pending.
//   Adjacent transition during DIVIDE: latch period and direction into 1-deep pending reg.
//    A newer transition overwrites it. Counter restarts as normal.
//  Arithmetic: 32-bit unsigned quotient. If >32767, magnitude=32767. Sign from direction of the
//   transition that started the divide. Reverse gives -magnitude; -32768 never produced.
//  Direction reversal: period measured across the reversal is used as is; sign from new direction.
//  error_clear and a new error in the same cycle: error wins (hall_error stays 1).
//  velocity_valid never asserted on two consecutive cycles.
// TESTING (bench overrides: VEL_NUMERATOR=100000, TIMEOUT_CYCLES=5000)
//  1 Forward sequence, one step every 1000 clk -> priming step gives no pulse.
//    Each later step -> velocity=+100, valid 33 clk after strobe, direction=1.
//  2 Reverse steps every 500 clk -> velocity=-200, direction=0.
//    Reversal mid-run: first reverse step gives a negative value.
//  3 Steps every 2 clk (hold 2 cycles) -> quotient 50000 saturates, velocity=+32767.
//    Pending reg carries overlapped transitions, one valid pulse per completed divide.
//  4 Run at +100, then hold hall constant -> exactly 5000 cycles after last strobe:
//    velocity=0, one valid pulse. Next step primes only; the step after updates.
//  5 Inject 111 mid-run -> hall_error=1, velocity and counter unaffected.
//    Jump 001->010 -> hall_error=1, re-prime. error_clear -> 0.
//  6 Assert reset_n low 10 cycles into a divide -> all outputs at reset values immediately.
//    No pulse after release until two further adjacent steps.

Source files
------------

// File: rtl/hall_velocity_estimator.sv
// Hall-sensor velocity estimator for the BLDC PI velocity loop.
// Synchronises the three hall inputs, validates commutation steps, measures
// the clk-cycle period between adjacent steps and converts it to a signed,
// saturated velocity with a 1-bit/clk restoring divider. A stalled rotor is
// reported as zero velocity once the period counter reaches TIMEOUT_CYCLES.
module hall_velocity_estimator #(
    parameter logic [31:0] VEL_NUMERATOR = 32'd50_000_000,
    parameter int PERIOD_WIDTH = 24,
    parameter logic [PERIOD_WIDTH-1:0] TIMEOUT_CYCLES = PERIOD_WIDTH'(5_000_000)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  hall_raw,
    input  logic        error_clear,
    output logic [15:0] velocity,
    output logic        velocity_valid,
    output logic        direction,
    output logic        hall_error
);

    typedef enum logic [1:0] {
        ST_UNPRIMED,
        ST_PRIMED,
        ST_DIVIDE
    } state_t;

    localparam logic [2:0] IDX_NONE  = 3'd7;
    localparam logic [5:0] DIV_STEPS = 6'd32;

    // Position of a hall code in the forward commutation order; IDX_NONE for 000/111.
    function automatic logic [2:0] code_index(input logic [2:0] code);
        case (code)
            3'b001:  code_index = 3'd0;
            3'b011:  code_index = 3'd1;
            3'b010:  code_index = 3'd2;
            3'b110:  code_index = 3'd3;
            3'b100:  code_index = 3'd4;
            3'b101:  code_index = 3'd5;
            default: code_index = IDX_NONE;
        endcase
    endfunction

    // Input synchroniser and step history
    logic [2:0] sync1, sync2;
    logic [2:0] hist_q, hist_d;

    // Step decode
    logic [2:0] new_idx, hist_idx;
    logic [3:0] idx_sum, idx_diff;
    logic       strobe, code_ok, hist_ok, step_fwd, step_rev;
    logic       ev_invalid, ev_load, ev_adj, ev_jump;

    // Period measurement
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;

    // Control FSM and divider
    state_t                  state_q, state_d;
    logic [5:0]              div_cnt_q, div_cnt_d;
    logic [PERIOD_WIDTH-1:0] divisor_q, divisor_d;
    logic                    div_dir_q, div_dir_d;
    logic [PERIOD_WIDTH-1:0] rem_q, rem_d;
    logic [31:0]             quo_q, quo_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [PERIOD_WIDTH-1:0] pend_period_q, pend_period_d;
    logic                    pend_dir_q, pend_dir_d;

    // Output next-state values
    logic [15:0] vel_d;
    logic        valid_d, dir_d, err_d;

    // Divider step and result formatting
    logic [PERIOD_WIDTH:0]   trial, trial_sub;
    logic                    trial_ge;
    logic [14:0]             mag;
    logic [15:0]             result;

    // Two-flop synchroniser for the asynchronous hall inputs
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state is always assigned with <= so every flop samples
        // the pre-edge value of its sources, independent of statement order.
        if (!reset_n) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
        end else begin
            sync1 <= hall_raw;
            sync2 <= sync1;
        end
    end

    // Classify a change of the synchronised code against the last accepted code
    always_comb begin
        new_idx    = code_index(sync2);
        hist_idx   = code_index(hist_q);
        strobe     = (sync2 != hist_q);
        code_ok    = (new_idx != IDX_NONE);
        hist_ok    = (hist_idx != IDX_NONE);
        idx_sum    = {1'b0, new_idx} + 4'd6 - {1'b0, hist_idx};
        idx_diff   = (idx_sum >= 4'd6) ? idx_sum - 4'd6 : idx_sum;
        step_fwd   = (idx_diff == 4'd1);
        step_rev   = (idx_diff == 4'd5);
        ev_invalid = strobe && !code_ok;
        // History still holds the post-reset 000: take the first valid code silently.
        ev_load    = strobe && code_ok && !hist_ok;
        ev_adj     = strobe && code_ok && hist_ok && (step_fwd || step_rev);
        ev_jump    = strobe && code_ok && hist_ok && !(step_fwd || step_rev);
    end

    // History, period counter, direction and sticky error tracking
    always_comb begin
        hist_d = hist_q;
        dir_d  = direction;
        err_d  = hall_error;
        if (strobe && code_ok) begin
            hist_d = sync2;
        end
        if (ev_load || ev_adj || ev_jump) begin
            cnt_d = PERIOD_WIDTH'(1);
        end else if (cnt_q < TIMEOUT_CYCLES) begin
            cnt_d = cnt_q + PERIOD_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (ev_adj) begin
            dir_d = step_fwd;
        end
        // A fresh error outranks a clear arriving in the same cycle.
        if (ev_invalid || ev_jump) begin
            err_d = 1'b1;
        end else if (error_clear) begin
            err_d = 1'b0;
        end
    end

    // One restoring-division step and saturated, signed formatting of the quotient
    always_comb begin
        trial     = {rem_q, quo_q[31]};
        trial_sub = trial - {1'b0, divisor_q};
        trial_ge  = (trial >= {1'b0, divisor_q});
        mag       = (quo_q > 32'd32767) ? 15'h7fff : quo_q[14:0];
        result    = div_dir_q ? {1'b0, mag} : 16'd0 - {1'b0, mag};
    end

    // Next-state and datapath control for prime / measure / divide
    always_comb begin
        // NOTE: every variable gets a default here first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d       = state_q;
        div_cnt_d     = div_cnt_q;
        divisor_d     = divisor_q;
        div_dir_d     = div_dir_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        pend_valid_d  = pend_valid_q;
        pend_period_d = pend_period_q;
        pend_dir_d    = pend_dir_q;
        vel_d         = velocity;
        valid_d       = 1'b0;

        case (state_q)
            ST_UNPRIMED: begin
                if (ev_adj) begin
                    state_d = ST_PRIMED;
                end
            end

            ST_PRIMED: begin
                if (ev_adj) begin
                    divisor_d = cnt_q;
                    div_dir_d = step_fwd;
                    rem_d     = '0;
                    quo_d     = VEL_NUMERATOR;
                    div_cnt_d = '0;
                    state_d   = ST_DIVIDE;
                end else if (ev_jump) begin
                    state_d = ST_UNPRIMED;
                end else if (cnt_q >= TIMEOUT_CYCLES) begin
                    vel_d   = '0;
                    valid_d = 1'b1;
                    state_d = ST_UNPRIMED;
                end
            end

            ST_DIVIDE: begin
                if (ev_jump) begin
                    // Lost track of the rotor: drop the divide and any queued period.
                    pend_valid_d = 1'b0;
                    state_d      = ST_UNPRIMED;
                end else if (div_cnt_q != DIV_STEPS) begin
                    rem_d     = trial_ge ? trial_sub[PERIOD_WIDTH-1:0] : trial[PERIOD_WIDTH-1:0];
                    quo_d     = {quo_q[30:0], trial_ge};
                    div_cnt_d = div_cnt_q + 6'd1;
                    if (ev_adj) begin
                        pend_valid_d  = 1'b1;
                        pend_period_d = cnt_q;
                        pend_dir_d    = step_fwd;
                    end
                end else begin
                    vel_d   = result;
                    valid_d = 1'b1;
                    if (pend_valid_q) begin
                        divisor_d = pend_period_q;
                        div_dir_d = pend_dir_q;
                        rem_d     = '0;
                        quo_d     = VEL_NUMERATOR;
                        div_cnt_d = '0;
                        if (ev_adj) begin
                            pend_period_d = cnt_q;
                            pend_dir_d    = step_fwd;
                        end else begin
                            pend_valid_d = 1'b0;
                        end
                    end else if (ev_adj) begin
                        divisor_d = cnt_q;
                        div_dir_d = step_fwd;
                        rem_d     = '0;
                        quo_d     = VEL_NUMERATOR;
                        div_cnt_d = '0;
                    end else begin
                        state_d = ST_PRIMED;
                    end
                end
            end

            default: begin
                state_d = ST_UNPRIMED;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_UNPRIMED;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q         <= 3'b000;
            cnt_q          <= '0;
            div_cnt_q      <= '0;
            divisor_q      <= '0;
            div_dir_q      <= 1'b1;
            rem_q          <= '0;
            quo_q          <= '0;
            pend_valid_q   <= 1'b0;
            pend_period_q  <= '0;
            pend_dir_q     <= 1'b1;
            velocity       <= '0;
            velocity_valid <= 1'b0;
            direction      <= 1'b1;
            hall_error     <= 1'b0;
        end else begin
            hist_q         <= hist_d;
            cnt_q          <= cnt_d;
            div_cnt_q      <= div_cnt_d;
            divisor_q      <= divisor_d;
            div_dir_q      <= div_dir_d;
            rem_q          <= rem_d;
            quo_q          <= quo_d;
            pend_valid_q   <= pend_valid_d;
            pend_period_q  <= pend_period_d;
            pend_dir_q     <= pend_dir_d;
            velocity       <= vel_d;
            velocity_valid <= valid_d;
            direction      <= dir_d;
            hall_error     <= err_d;
        end
    end

endmodule
